// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit datapath: field layout, opcodes,
// immediate-class membership and the decoded-word record.
package cpu_pkg;

    localparam int DATA_W  = 16;
    localparam int FIELD_W = 4;
    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 8;
    localparam int RS_LSB  = 4;
    localparam int RT_LSB  = 0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADDI = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_LW   = 4'h4,
        OP_SW   = 4'h5,
        OP_OR   = 4'h6,
        OP_BEQ  = 4'h7,
        OP_JMP  = 4'h8
    } opcode_e;

    // One bit per opcode value; set bits use the rt field as imm4.
    localparam logic [15:0] IMM_CLASS_MASK = (16'd1 << OP_ADDI) | (16'd1 << OP_LW)
                                           | (16'd1 << OP_SW)   | (16'd1 << OP_BEQ);

    typedef struct packed {
        logic [FIELD_W-1:0] opcode;
        logic [FIELD_W-1:0] rd;
        logic [FIELD_W-1:0] rs;
        logic [FIELD_W-1:0] rt;
    } dec_word_t;

    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_e;

    function automatic dec_word_t split_fields(input logic [DATA_W-1:0] w);
        dec_word_t d;
        d.opcode = w[OPC_LSB +: FIELD_W];
        d.rd     = w[RD_LSB  +: FIELD_W];
        d.rs     = w[RS_LSB  +: FIELD_W];
        d.rt     = w[RT_LSB  +: FIELD_W];
        return d;
    endfunction

    function automatic logic is_imm_op(input logic [FIELD_W-1:0] op);
        return IMM_CLASS_MASK[op];
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// master = surrounding pipeline, slave = id_stage.
interface id_stage_if;
    import cpu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_instr;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_opcode;
    logic [3:0]        out_rd;
    logic [3:0]        out_rs;
    logic [3:0]        out_rt;
    logic [3:0]        out_imm4;
    logic [DATA_W-1:0] out_imm16;
    logic              out_is_imm;
    logic [15:0]       dec_count;

    modport master (
        output in_valid, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt,
               out_imm4, out_imm16, out_is_imm, dec_count
    );

    modport slave (
        input  in_valid, in_instr, flush, out_ready,
        output in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt,
               out_imm4, out_imm16, out_is_imm, dec_count
    );

endinterface

// File: rtl/id_skid_buf.sv
// Generic valid/ready two-entry skid buffer: main entry drives the output,
// skid entry absorbs one word while stalled; in_ready is a flop.
module id_skid_buf
    import cpu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    skid_state_e  state_reg,      state_next;
    logic         main_valid_reg, main_valid_next;
    logic [W-1:0] main_data_reg,  main_data_next;
    logic [W-1:0] skid_data_reg,  skid_data_next;
    logic         ready_reg,      ready_next;
    logic         in_xfer;
    logic         out_xfer;

    assign in_xfer   = in_valid && ready_reg;
    assign out_xfer  = main_valid_reg && out_ready;
    assign in_ready  = ready_reg;
    assign out_valid = main_valid_reg;
    assign out_data  = main_data_reg;

    // ready_reg resets low so that in_ready rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= SKID_EMPTY;
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            skid_data_reg  <= '0;
            ready_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            main_valid_reg <= main_valid_next;
            main_data_reg  <= main_data_next;
            skid_data_reg  <= skid_data_next;
            ready_reg      <= ready_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        skid_data_next  = skid_data_reg;
        if (flush) begin
            state_next      = SKID_EMPTY;
            main_valid_next = 1'b0;
        end else begin
            case (state_reg)
                SKID_EMPTY: begin
                    if (in_xfer) begin
                        if (!main_valid_reg || out_ready) begin
                            main_data_next  = in_data;
                            main_valid_next = 1'b1;
                        end else begin
                            skid_data_next = in_data;
                            state_next     = SKID_FULL;
                        end
                    end else if (out_xfer) begin
                        main_valid_next = 1'b0;
                    end
                end
                SKID_FULL: begin
                    if (out_xfer) begin
                        main_data_next = skid_data_reg;
                        state_next     = SKID_EMPTY;
                    end
                end
                default: state_next = SKID_EMPTY;
            endcase
        end
        ready_next = (state_next == SKID_EMPTY);
    end

endmodule

// File: rtl/sign_ext4.sv
// 4-to-16 sign extender feeding the ALU immediate operand.
module sign_ext4 (
    input  logic [3:0]  imm4,
    output logic [15:0] imm16
);
    assign imm16[3:0] = imm4;

    for (genvar gi = 4; gi < 16; gi++) begin : g_ext
        assign imm16[gi] = imm4[3];
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: registers fetched words and presents decoded fields.
// Define IDSKID_EN for a two-entry skid buffer with registered in_ready.
module id_stage
    import cpu_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    id_stage_if.slave bus
);
    logic              main_valid;
    logic [DATA_W-1:0] main_word;
    logic              in_ready;
    dec_word_t         dec;
    logic [DATA_W-1:0] imm16;
    logic [15:0]       dec_count_reg;

`ifdef IDSKID_EN
    id_skid_buf #(.W(DATA_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (in_ready),
        .in_data   (bus.in_instr),
        .out_valid (main_valid),
        .out_ready (bus.out_ready),
        .out_data  (main_word)
    );
`else
    logic              main_valid_reg;
    logic [DATA_W-1:0] main_word_reg;
    logic              in_xfer;

    // Combinational ready: a held word can be replaced when execute takes it.
    assign in_ready = !main_valid_reg || bus.out_ready;
    assign in_xfer  = bus.in_valid && in_ready && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_reg <= 1'b0;
            main_word_reg  <= '0;
        end else if (bus.flush) begin
            main_valid_reg <= 1'b0;
        end else if (in_xfer) begin
            main_valid_reg <= 1'b1;
            main_word_reg  <= bus.in_instr;
        end else if (bus.out_ready) begin
            main_valid_reg <= 1'b0;
        end
    end

    assign main_valid = main_valid_reg;
    assign main_word  = main_word_reg;
`endif

    // Output transfers count even in a flush cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_count_reg <= '0;
        end else if (main_valid && bus.out_ready) begin
            dec_count_reg <= dec_count_reg + 16'd1;
        end
    end

    assign dec = split_fields(main_word);

    sign_ext4 u_sext (
        .imm4  (dec.rt),
        .imm16 (imm16)
    );

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = main_valid;
    assign bus.out_opcode = dec.opcode;
    assign bus.out_rd     = dec.rd;
    assign bus.out_rs     = dec.rs;
    assign bus.out_rt     = dec.rt;
    assign bus.out_imm4   = dec.rt;
    assign bus.out_imm16  = imm16;
    assign bus.out_is_imm = is_imm_op(dec.opcode);
    assign bus.dec_count  = dec_count_reg;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode pipeline stage for the 16-bit datapath. It accepts fetched instruction words over a valid/ready handshake and registers them. It splits each word into opcode and register fields and produces both the raw 4-bit immediate and its 16-bit sign-extended form for the ALU operand mux. It sits between instruction fetch (upstream) and execute (downstream), and it is the block that feeds the 4-bit sign extender.

## Interface
- `DATA_W`, 16: instruction and extended-immediate width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `in_valid`  in  1  fetch presents an instruction word.
- `in_ready`  out  1  stage can accept a word this cycle.
- `in_instr`  in  16  instruction word; layout is [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt/imm4.
- `flush`  in  1  synchronous discard of all held words (branch redirect).
- `out_valid`  out  1  decoded word available.
- `out_ready`  in  1  execute accepts the decoded word.
- `out_opcode`  out  4  opcode field.
- `out_rd`, `out_rs`, `out_rt`  out  4 each  register fields. `out_rt` equals `imm4`.
- `out_imm4`  out  4  raw immediate.
- `out_imm16`  out  16  `{{12{imm4[3]}}, imm4}`.
- `out_is_imm`  out  1  opcode belongs to the immediate class (package list).
- `dec_count`  out  16  count of words handed to execute; wraps.

## Operation
- A transfer occurs when `valid && ready` on the same edge, on either side.
- The main register holds one decoded word. All field outputs are driven from the main register, so every output is registered.
- Decode is performed on the registered word. `out_imm16` comes from the sign-extension instance on `out_imm4`, which is combinational from a register.
- `dec_count` increments on each output transfer and wraps from 0xFFFF to 0x0000.
- `flush` takes priority over every other event:
  - `out_valid` and the skid entry (if present) clear on the next edge.
  - An `in_valid` word offered in the flush cycle is dropped.
  - An output transfer in the flush cycle still counts.
- Simultaneous input and output transfer with one word held: the new word replaces the old one, and occupancy is unchanged.
- Reset (asynchronous, at any time, including mid-stall):
  - `out_valid`=0 and every field output is 0, so `out_imm16`=0x0000.
  - `dec_count`=0, and the skid entry is empty.
  - `in_ready` goes to 1 on the first edge after release (`IDSKID_EN`) or is 1 immediately (without it).

## Timing
- Latency is 1 cycle: a word accepted at edge N appears on the outputs after edge N, with `out_valid`=1.
- Throughput is one word per cycle under continuous `out_ready`.
- Without the macro, `in_ready = !out_valid || out_ready`, which is a combinational path from `out_ready`.
- With the macro, `in_ready` is registered and equals "skid empty". The skid states are:
  - EMPTY: main register may hold a word; skid entry is empty.
  - FULL: main register and skid entry both hold words.
- EMPTY -> FULL: an input transfer while main is valid and `out_ready`=0.
- FULL -> EMPTY: an output transfer; the skid word moves into main on that edge.
- FULL: `in_valid` is ignored because `in_ready`=0.

## Configuration
- `IDSKID_EN` defined: a two-entry skid buffer, giving a registered `in_ready`. It absorbs one extra word while stalled and breaks the fetch–execute ready path.
- `IDSKID_EN` undefined: a single register with combinational ready as above. The one-word capacity gives identical data ordering and field values.

## Structure
- Shared package `cpu_pkg`:
  - `DATA_W`.
  - Field bit positions.
  - Opcode constants.
  - The immediate-class opcode list: 0x1 ADDI, 0x4 LW, 0x5 SW, 0x7 BEQ.
  - The decoded-word struct (opcode, rd, rs, rt).
- Sub-module `id_skid_buf`: generic valid/ready two-entry buffer, instantiated only under `IDSKID_EN`.
- Sign extension uses the existing 4-to-16 extender instance. The stage does not reimplement it.

## Test plan
- Reset then `in_instr`=0x1237, `in_valid`=1, `out_ready`=1 -> one cycle later the outputs are:
  - opcode=1, rd=2, rs=3, imm4=7, `out_imm16`=0x0007, `out_is_imm`=1.
- `in_instr`=0x4568 -> `out_imm16`=0xFFF8; 0x7ABF -> 0xFFFF; 0x000A -> 0xFFFA; 0x2340 -> 0x0000 with `out_is_imm`=0.
- `out_ready`=0 for 4 cycles while words A, B, C are offered back-to-back:
  - With `IDSKID_EN`: A and B are accepted, `in_ready`=0 on C.
  - Without it: only A is accepted.
  - After `out_ready`=1: A, B, C emerge in order, with no drops or duplicates.
- Main and skid entries full, `flush`=1 together with `in_valid`=1 ->
  - next cycle `out_valid`=0, `in_ready`=1, and no held or offered word ever appears.
- Preload `dec_count` to 0xFFFE via 2 transfers after forcing, or run 65536 transfers -> it wraps to 0x0000.
- Assert `rst_n`=0 mid-stall between edges ->
  - `out_valid`, `dec_count`, and `out_imm16` are 0 immediately, before the next edge.
  - The stall releases cleanly after deassert.
